weighted_rr_burst_arbiter: RTL and testbench
============================================

// Module: weighted_rr_burst_arbiter
// PURPOSE
// Shares one downstream valid/ready channel (e.g. a crossbar slave-port AW/AR/W path) between NumIn requesters.
// Weighted round-robin: the granted requester keeps the channel for up to weight_i[idx] consecutive handshakes.
// Then the pointer moves to the next requesting index. Output request/data are registered-select, stable until accepted.
// PARAMETERS
// NumIn       4      number of requesters; must be >= 2
// DataType    logic  payload type carried per requester
// WeightW     4      width of each per-requester weight (credit count)
// StarveLimit 15     wait cycles before starvation boost (used only with WRR_ARB_STARVE_EN)
// PORTS
// clk_i     in   1                    clock
// rst_i     in   1                    reset, asynchronous, active-high
// flush_i   in   1                    synchronous abort of current selection
// req_i     in   NumIn                per-requester valid; held until its gnt_o bit
// data_i    in   NumIn x DataType     per-requester payload
// weight_i  in   NumIn x WeightW      per-requester credit; sampled at selection; 0 treated as 1
// gnt_o     out  NumIn                per-requester ready (one-hot or zero)
// req_o     out  1                    downstream valid
// data_o    out  DataType             downstream payload
// idx_o     out  $clog2(NumIn)        index of selected requester
// gnt_i     in   1                    downstream ready
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high.
// - Reset: state=IDLE, ptr=0, sel=0, credit=0; req_o=0, gnt_o=0, data_o='0, idx_o=0.
// - State machine: IDLE, BUSY.
// - IDLE, |req_i: scan from ptr upward with wrap; lowest-distance requester -> sel.
//   Load credit = max(weight_i[sel],1); go BUSY. No request: stay IDLE.
// - BUSY outputs (combinational from sel): req_o=req_i[sel], data_o=data_i[sel], idx_o=sel, gnt_o[sel]=gnt_i.
// - IDLE outputs are all zero; gnt_o is never asserted in IDLE.
// - Latency: request arriving in IDLE -> req_o on the next cycle.
//   Chained beats of one requester: zero bubble. Switching requester: exactly 1 idle cycle.
// - Handshake = req_o && gnt_i. On handshake:
//   credit==1 -> IDLE, ptr=(sel+1)%NumIn. Else credit-=1, stay BUSY.
// - BUSY && !req_i[sel] (requester emptied mid-chain) -> IDLE, ptr=(sel+1)%NumIn, remaining credit discarded.
// - Wrap-around: ptr NumIn-1 -> 0. Scan covers all NumIn indices, including ptr itself.
// - weight_i changes while BUSY do not affect the loaded credit.
// - flush_i: forces req_o=0 and gnt_o=0 in the same cycle (no handshake counted).
//   Next state IDLE, ptr=0, credit=0. Flush overrides all other events, including gnt_i in the same cycle.
// - Simultaneous last-credit handshake and new requests: 1 idle cycle, then selection from new ptr.
// - Requesters obey valid-stable: req_i[k] and data_i[k] must not change while req_i[k] && !gnt_o[k].
// CONFIGURATION
// - WRR_ARB_STARVE_EN defined:
//   - Per-requester wait counter (width $clog2(StarveLimit+1)).
//   - Counter increments each cycle req_i[k] && !gnt_o[k]; clears on that requester's handshake, on flush, and on reset.
//   - Counter saturates at StarveLimit; a requester at StarveLimit is "starved".
//   - While any requester is starved, the BUSY chain ends at the next handshake (treated as credit==1).
//   - IDLE selection then picks the lowest-index starved requester, ignoring ptr.
//   - ptr update still uses (sel+1).
// - WRR_ARB_STARVE_EN undefined: no counters, pure weighted round-robin as above; StarveLimit unused.
// TESTING
// - Reset with req_i=4'b1111 held -> all outputs 0 during reset. First cycle after release: IDLE.
//   Next cycle: req_o=1, idx_o=0.
// - weights {1,2,3,1}, all requesting, gnt_i=1 -> handshake idx sequence 0,_,1,1,_,2,2,2,_,3,_,0 (_ = idle cycle).
// - req_i=4'b1000 only, weight 2, ptr=0 -> wrap scan selects 3. After 2 handshakes, ptr=0.
// - Requester 1 drops req after 1 of 3 credits -> IDLE next cycle, ptr=2, credit discarded.
// - flush_i with gnt_i=1 while BUSY sel=2 -> gnt_o=0 and req_o=0 that cycle. Then IDLE, ptr=0.
// - WRR_ARB_STARVE_EN, StarveLimit=3: weight0=15, req 0 and 2 held, gnt_i=1
//   -> chain on 0 cut once cnt2==3; next selection idx_o=2.

Source files
------------

// File: rtl/weighted_rr_burst_arbiter.sv
// weighted_rr_burst_arbiter
//   Shares one downstream valid/ready channel between NumIn requesters.
//   Weighted round-robin: the selected requester keeps the channel for up to
//   max(weight_i[sel],1) consecutive handshakes. After that the pointer moves to
//   sel+1 and the next selection scans upward from it, wrapping around.
//   Switching requesters costs one idle cycle. Beats chained from one
//   requester have no bubble between them.
//
// Optional feature macro: WRR_ARB_STARVE_EN
//   Adds per-requester wait counters. While any requester has waited
//   StarveLimit cycles, the current chain ends at its next handshake. The
//   following selection takes the lowest-index starved requester.
//
// Ports
//   clk_i     clock
//   rst_i     asynchronous, active-high reset
//   flush_i   synchronous abort; masks req_o/gnt_o in the same cycle
//   req_i     per-requester valid (held until its gnt_o bit)
//   data_i    per-requester payload
//   weight_i  per-requester credit, sampled at selection (0 acts as 1)
//   gnt_o     per-requester ready (one-hot or zero)
//   req_o     downstream valid
//   data_o    downstream payload
//   idx_o     index of the selected requester
//   gnt_i     downstream ready
module weighted_rr_burst_arbiter #(
  parameter int unsigned NumIn       = 4,
  parameter type         DataType    = logic,
  parameter int unsigned WeightW     = 4,
  parameter int unsigned StarveLimit = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [NumIn-1:0]           req_i,
  input  DataType                    data_i   [NumIn],
  input  logic [WeightW-1:0]         weight_i [NumIn],
  output logic [NumIn-1:0]           gnt_o,
  output logic                       req_o,
  output DataType                    data_o,
  output logic [$clog2(NumIn)-1:0]   idx_o,
  input  logic                       gnt_i
);

  localparam int unsigned IdxW = $clog2(NumIn);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    sel_q;
  logic [WeightW-1:0] credit_q;

  logic [IdxW-1:0]    pick;
  logic               found;
  logic               starve_any;
  logic [IdxW-1:0]    ptr_next;

  assign ptr_next = (sel_q == IdxW'(NumIn - 1)) ? '0 : sel_q + 1'b1;

  // Outputs are driven from the registered selection. A flush masks them in
  // the same cycle, so no handshake can happen while flush_i is high.
  always_comb begin
    req_o  = 1'b0;
    data_o = '0;
    idx_o  = '0;
    gnt_o  = '0;
    if (state_q == BUSY && !flush_i) begin
      req_o        = req_i[sel_q];
      data_o       = data_i[sel_q];
      idx_o        = sel_q;
      gnt_o[sel_q] = gnt_i;
    end
  end

`ifdef WRR_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(StarveLimit + 1);

  logic [CntW-1:0]  wait_q [NumIn];
  logic [NumIn-1:0] starved;

  always_comb begin
    starved = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      starved[IdxW'(k)] = (wait_q[IdxW'(k)] == CntW'(StarveLimit));
    end
  end

  assign starve_any = |starved;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NumIn; k++) wait_q[IdxW'(k)] <= '0;
    end else if (flush_i) begin
      for (int unsigned k = 0; k < NumIn; k++) wait_q[IdxW'(k)] <= '0;
    end else begin
      for (int unsigned k = 0; k < NumIn; k++) begin
        if (req_i[IdxW'(k)] && gnt_o[IdxW'(k)]) begin
          wait_q[IdxW'(k)] <= '0;
        end else if (req_i[IdxW'(k)] && !starved[IdxW'(k)]) begin
          wait_q[IdxW'(k)] <= wait_q[IdxW'(k)] + 1'b1;
        end
      end
    end
  end
`else
  assign starve_any = 1'b0;
`endif

  // The scan starts at ptr and wraps, so ptr itself is the closest candidate.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      automatic logic [IdxW-1:0] c;
      c = IdxW'((32'(ptr_q) + i) % NumIn);
      if (!found && req_i[c]) begin
        found = 1'b1;
        pick  = c;
      end
    end
`ifdef WRR_ARB_STARVE_EN
    if (|(starved & req_i)) begin
      found = 1'b0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        if (!found && starved[IdxW'(i)] && req_i[IdxW'(i)]) begin
          found = 1'b1;
          pick  = IdxW'(i);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      credit_q <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            sel_q    <= pick;
            credit_q <= (weight_i[pick] == '0) ? WeightW'(1) : weight_i[pick];
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (!req_i[sel_q]) begin
            state_q  <= IDLE;
            ptr_q    <= ptr_next;
            credit_q <= '0;
          end else if (gnt_i) begin
            if (credit_q == WeightW'(1) || starve_any) begin
              state_q  <= IDLE;
              ptr_q    <= ptr_next;
              credit_q <= '0;
            end else begin
              credit_q <= credit_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_rr_burst_arbiter.sv
// Directed testbench for weighted_rr_burst_arbiter (NumIn=4, 8-bit payload).
// Inputs change 1 time unit after the rising edge. Outputs are checked on the
// falling edge.
module tb_weighted_rr_burst_arbiter;

  logic             clk_i;
  logic             rst_i;
  logic             flush_i;
  logic [3:0]       req_i;
  logic [7:0]       data_i   [4];
  logic [3:0]       weight_i [4];
  logic [3:0]       gnt_o;
  logic             req_o;
  logic [7:0]       data_o;
  logic [1:0]       idx_o;
  logic             gnt_i;

  int n_tests;
  int n_fail;

  weighted_rr_burst_arbiter #(
    .NumIn      (4),
    .DataType   (logic [7:0]),
    .WeightW    (4),
    .StarveLimit(3)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .weight_i(weight_i),
    .gnt_o   (gnt_o),
    .req_o   (req_o),
    .data_o  (data_o),
    .idx_o   (idx_o),
    .gnt_i   (gnt_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    flush_i = 1'b0;
    req_i   = 4'b0000;
    gnt_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    flush_i = 1'b0;
    gnt_i   = 1'b0;
    req_i   = 4'b1111;
    for (int k = 0; k < 4; k++) weight_i[k] = 4'd1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_o: got %b want 0", req_o); end
    n_tests++;
    if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_o: got %b want 0000", gnt_o); end
    n_tests++;
    if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data_o: got %h want 00", data_o); end
    n_tests++;
    if (idx_o !== 2'd0) begin n_fail++; $display("FAIL reset_idx_o: got %0d want 0", idx_o); end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_first_idle: got req_o=%b want 0", req_o); end
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b1 || idx_o !== 2'd0 || data_o !== 8'hA0)
      begin n_fail++; $display("FAIL reset_first_select: got req_o=%b idx=%0d data=%h want 1 0 a0", req_o, idx_o, data_o); end
  endtask

  task automatic test_weighted();
    int exp_idx [13];
    exp_idx = '{-1, 0, -1, 1, 1, -1, 2, 2, 2, -1, 3, -1, 0};
    do_reset();
    weight_i[0] = 4'd1; weight_i[1] = 4'd2; weight_i[2] = 4'd3; weight_i[3] = 4'd1;
    req_i = 4'b1111;
    gnt_i = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk_i);
      n_tests++;
      if (exp_idx[c] < 0) begin
        if (req_o !== 1'b0 || gnt_o !== 4'b0000)
          begin n_fail++; $display("FAIL weighted_c%0d: got req_o=%b gnt_o=%b want idle", c, req_o, gnt_o); end
      end else if (req_o !== 1'b1 || idx_o !== 2'(exp_idx[c]) || gnt_o !== (4'b0001 << exp_idx[c])) begin
        n_fail++;
        $display("FAIL weighted_c%0d: got req_o=%b idx=%0d gnt_o=%b want idx %0d", c, req_o, idx_o, gnt_o, exp_idx[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 4; k++) weight_i[k] = 4'd1;
    weight_i[3] = 4'd2;
    req_i = 4'b1000;
    gnt_i = 1'b1;
    next_cycle();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk_i);
      n_tests++;
      if (req_o !== 1'b1 || idx_o !== 2'd3 || data_o !== 8'hA3 || gnt_o !== 4'b1000)
        begin n_fail++; $display("FAIL wrap_beat%0d: got req_o=%b idx=%0d data=%h gnt=%b want 1 3 a3 1000", c, req_o, idx_o, data_o, gnt_o); end
      next_cycle();
    end
    req_i = 4'b1001;
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got req_o=%b want 0", req_o); end
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b1 || idx_o !== 2'd0)
      begin n_fail++; $display("FAIL wrap_ptr0: got req_o=%b idx=%0d want 1 0", req_o, idx_o); end
  endtask

  task automatic test_stall_zero_weight();
    do_reset();
    for (int k = 0; k < 4; k++) weight_i[k] = 4'd0;
    req_i = 4'b0110;
    gnt_i = 1'b0;
    next_cycle();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk_i);
      n_tests++;
      if (req_o !== 1'b1 || idx_o !== 2'd1 || gnt_o !== 4'b0000)
        begin n_fail++; $display("FAIL stall_c%0d: got req_o=%b idx=%0d gnt=%b want 1 1 0000", c, req_o, idx_o, gnt_o); end
      next_cycle();
    end
    gnt_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL zero_weight_hs: got gnt=%b want 0010", gnt_o); end
    next_cycle();
    req_i = 4'b0100;
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL zero_weight_end: got req_o=%b want 0", req_o); end
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b1 || idx_o !== 2'd2)
      begin n_fail++; $display("FAIL zero_weight_next: got req_o=%b idx=%0d want 1 2", req_o, idx_o); end
  endtask

  task automatic test_drop();
    do_reset();
    for (int k = 0; k < 4; k++) weight_i[k] = 4'd3;
    req_i = 4'b0010;
    gnt_i = 1'b1;
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b1 || idx_o !== 2'd1)
      begin n_fail++; $display("FAIL drop_first: got req_o=%b idx=%0d want 1 1", req_o, idx_o); end
    next_cycle();
    req_i = 4'b0101;
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL drop_empty: got req_o=%b want 0", req_o); end
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got req_o=%b want 0", req_o); end
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b1 || idx_o !== 2'd2)
      begin n_fail++; $display("FAIL drop_ptr2: got req_o=%b idx=%0d want 1 2", req_o, idx_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 4; k++) weight_i[k] = 4'd1;
    weight_i[2] = 4'd3;
    req_i = 4'b0010;
    gnt_i = 1'b1;
    next_cycle();
    next_cycle();
    req_i = 4'b0100;
    gnt_i = 1'b0;
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b1 || idx_o !== 2'd2)
      begin n_fail++; $display("FAIL flush_pre: got req_o=%b idx=%0d want 1 2", req_o, idx_o); end
    next_cycle();
    flush_i = 1'b1;
    gnt_i   = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0 || gnt_o !== 4'b0000)
      begin n_fail++; $display("FAIL flush_mask: got req_o=%b gnt=%b want 0 0000", req_o, gnt_o); end
    next_cycle();
    flush_i = 1'b0;
    gnt_i   = 1'b0;
    req_i   = 4'b0110;
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got req_o=%b want 0", req_o); end
    next_cycle();
    @(negedge clk_i);
    n_tests++;
    if (req_o !== 1'b1 || idx_o !== 2'd1)
      begin n_fail++; $display("FAIL flush_ptr0: got req_o=%b idx=%0d want 1 1", req_o, idx_o); end
  endtask

`ifdef WRR_ARB_STARVE_EN
  task automatic test_starve();
    int exp_idx [6];
    exp_idx = '{-1, 0, 0, 0, -1, 2};
    do_reset();
    for (int k = 0; k < 4; k++) weight_i[k] = 4'd1;
    weight_i[0] = 4'd15;
    req_i = 4'b0101;
    gnt_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      n_tests++;
      if (exp_idx[c] < 0) begin
        if (req_o !== 1'b0) begin n_fail++; $display("FAIL starve_c%0d: got req_o=%b want 0", c, req_o); end
      end else if (req_o !== 1'b1 || idx_o !== 2'(exp_idx[c])) begin
        n_fail++;
        $display("FAIL starve_c%0d: got req_o=%b idx=%0d want idx %0d", c, req_o, idx_o, exp_idx[c]);
      end
      next_cycle();
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_i   = 1'b1;
    flush_i = 1'b0;
    gnt_i   = 1'b0;
    req_i   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      data_i[k]   = 8'hA0 + 8'(k);
      weight_i[k] = 4'd1;
    end
    test_reset();
    test_weighted();
    test_wrap();
    test_stall_zero_weight();
    test_drop();
    test_flush();
`ifdef WRR_ARB_STARVE_EN
    test_starve();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
